// File: rtl/rom_seq_ctrl.sv
// Fetch controller for the sequencer command ROM: reads words from a start address and
// presents each one on a valid/ready command port. Optional wrap-around build: ROM_SEQ_LOOP_EN.
module rom_seq_ctrl #(
    parameter int                    ROM_DEPTH  = 16,
    parameter int                    DATA_WIDTH = 13,
    parameter logic [DATA_WIDTH-1:0] END_WORD   = '1,
    localparam int                   AW         = $clog2(ROM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [AW-1:0]         start_addr_i,
    input  logic                  abort_i,
    output logic [31:0]           rom_addr_o,
    output logic                  rom_rden_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] cmd_data_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [AW:0]           word_cnt_o,
    output logic [2:0]            dbg_state_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CHK  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Command port: a word transfers on any cycle where cmd_valid_o and cmd_ready_i are
    // both 1; cmd_valid_o and cmd_data_o stay put until then, dropping only on abort/reset.
    logic [2:0]            r_state;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_cmd_data;
    logic [AW:0]           r_word_cnt;
    logic                  w_handshake;
    logic                  w_last_addr;
    logic [AW:0]           w_cnt_next;
`ifdef ROM_SEQ_LOOP_EN
    logic [AW-1:0]         r_start_addr;
`endif

    assign w_handshake = (r_state == S_OUT) && cmd_ready_i;
    assign w_last_addr = (r_addr == AW'(ROM_DEPTH - 1));

`ifdef ROM_SEQ_LOOP_EN
    // A looping sequence can run indefinitely, so the count sticks at its maximum.
    assign w_cnt_next = (&r_word_cnt) ? r_word_cnt : r_word_cnt + (AW+1)'(1);
`else
    assign w_cnt_next = r_word_cnt + (AW+1)'(1);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cmd_data <= '0;
            r_word_cnt <= '0;
`ifdef ROM_SEQ_LOOP_EN
            r_start_addr <= '0;
`endif
        end else begin
            // A handshake coinciding with abort still counts.
            if (w_handshake) begin
                r_word_cnt <= w_cnt_next;
            end
            if (abort_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_addr     <= start_addr_i;
                            r_word_cnt <= '0;
`ifdef ROM_SEQ_LOOP_EN
                            r_start_addr <= start_addr_i;
`endif
                            r_state    <= S_RD;
                        end
                    end
                    S_RD: begin
                        r_state <= S_CHK;
                    end
                    S_CHK: begin
                        if (rom_data_i == END_WORD) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cmd_data <= rom_data_i;
                            r_state    <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (cmd_ready_i) begin
                            if (w_last_addr) begin
`ifdef ROM_SEQ_LOOP_EN
                                r_addr  <= r_start_addr;
                                r_state <= S_RD;
`else
                                r_state <= S_DONE;
`endif
                            end else begin
                                r_addr  <= r_addr + AW'(1);
                                r_state <= S_RD;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rom_addr_o         = '0;
        rom_addr_o[AW-1:0] = r_addr;
    end

    assign rom_rden_o  = (r_state == S_RD);
    assign cmd_valid_o = (r_state == S_OUT);
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign cmd_data_o  = r_cmd_data;
    assign word_cnt_o  = r_word_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Directed bench for rom_seq_ctrl (default build): ROM model, sequence runs, abort/reset cases.
module tb_rom_seq_ctrl;

    localparam int DW = 13;
    localparam int AW = 4;
    localparam logic [DW-1:0] END_W = '1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] start_addr_i;
    logic          abort_i;
    logic [31:0]   rom_addr_o;
    logic          rom_rden_o;
    logic [DW-1:0] rom_data_i;
    logic [DW-1:0] cmd_data_o;
    logic          cmd_valid_o;
    logic          cmd_ready_i;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   word_cnt_o;
    logic [2:0]    dbg_state_o;

    logic [DW-1:0] rom_mem [16];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            tests = 0;
    int            fails = 0;
    int            done_cnt;
    bit            end_seen;
    bit            timed_out;

    rom_seq_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
        .abort_i(abort_i), .rom_addr_o(rom_addr_o), .rom_rden_o(rom_rden_o),
        .rom_data_i(rom_data_i), .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i), .busy_o(busy_o), .done_o(done_o),
        .word_cnt_o(word_cnt_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM instance model: registered read, gated by rden
    always @(posedge clk_i) begin
        if (rom_rden_o) rom_data_i <= rom_mem[rom_addr_o[3:0]];
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic init_rom();
        for (int i = 0; i < 16; i++) rom_mem[i] = DW'(13'h100 + i);
        rom_mem[0]  = 13'h001;
        rom_mem[1]  = 13'h002;
        rom_mem[2]  = END_W;
        rom_mem[3]  = 13'h0AA;
        rom_mem[4]  = END_W;
        rom_mem[5]  = 13'h055;
        rom_mem[6]  = END_W;
        rom_mem[14] = 13'h0E0;
        rom_mem[15] = 13'h0F0;
    endtask

    // Starts a sequence and monitors it until busy_o drops; poke re-asserts start_i throughout.
    task automatic run_seq(input logic [AW-1:0] addr, input bit poke, input int max_cyc);
        int n;
        got_q.delete();
        done_cnt = 0;
        end_seen = 0;
        start_addr_i = addr;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < max_cyc) begin
            if (poke) begin
                start_i = 1'b1;
                start_addr_i = 4'd14;
            end
            if (cmd_valid_o && cmd_data_o == END_W) end_seen = 1;
            if (cmd_valid_o && cmd_ready_i) got_q.push_back(cmd_data_o);
            if (done_o) done_cnt++;
            tick();
            n++;
        end
        start_i = 1'b0;
        timed_out = busy_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        tests++; if (rom_addr_o !== 32'd0) begin fails++; $display("FAIL reset_addr got=%0h exp=0", rom_addr_o); end
        tests++; if (rom_rden_o !== 1'b0) begin fails++; $display("FAIL reset_rden got=%b exp=0", rom_rden_o); end
        tests++; if (cmd_data_o !== 13'h0) begin fails++; $display("FAIL reset_data got=%0h exp=0", cmd_data_o); end
        tests++; if (cmd_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", cmd_valid_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done_o); end
        tests++; if (word_cnt_o !== 5'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        cmd_ready_i = 1'b1;
        exp_q = '{13'h001, 13'h002};
        run_seq(4'd0, 1'b0, 60);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_ncmd got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_cmd%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
        tests++; if (word_cnt_o !== 5'd2) begin fails++; $display("FAIL basic_cnt got=%0d exp=2", word_cnt_o); end
        tests++; if (end_seen !== 1'b0) begin fails++; $display("FAIL basic_endword got=%b exp=0", end_seen); end
    endtask

    task automatic test_latency();
        int n;
        cmd_ready_i = 1'b1;
        start_addr_i = 4'd5;
        start_i = 1'b1;
        tests++; if (rom_rden_o !== 1'b0) begin fails++; $display("FAIL lat_rden_T got=%b exp=0", rom_rden_o); end
        tick();
        start_i = 1'b0;
        tests++; if (rom_rden_o !== 1'b1) begin fails++; $display("FAIL lat_rden_T1 got=%b exp=1", rom_rden_o); end
        tests++; if (rom_addr_o !== 32'd5) begin fails++; $display("FAIL lat_addr_T1 got=%0d exp=5", rom_addr_o); end
        tick();
        tests++; if (rom_rden_o !== 1'b0) begin fails++; $display("FAIL lat_rden_T2 got=%b exp=0", rom_rden_o); end
        tests++; if (cmd_valid_o !== 1'b0) begin fails++; $display("FAIL lat_valid_T2 got=%b exp=0", cmd_valid_o); end
        tick();
        tests++; if (cmd_valid_o !== 1'b1) begin fails++; $display("FAIL lat_valid_T3 got=%b exp=1", cmd_valid_o); end
        tests++; if (cmd_data_o !== 13'h055) begin fails++; $display("FAIL lat_data_T3 got=%0h exp=55", cmd_data_o); end
        tick();
        tests++; if (rom_rden_o !== 1'b1) begin fails++; $display("FAIL lat_rden_T4 got=%b exp=1", rom_rden_o); end
        n = 0;
        while (busy_o && n < 20) begin tick(); n++; end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL lat_drain got=%b exp=0", busy_o); end
    endtask

    task automatic test_backpressure();
        int n;
        bit saw_done;
        cmd_ready_i = 1'b0;
        start_addr_i = 4'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!cmd_valid_o && n < 10) begin tick(); n++; end
        for (int k = 0; k < 4; k++) begin
            tests++; if (cmd_valid_o !== 1'b1) begin fails++; $display("FAIL bp_valid%0d got=%b exp=1", k, cmd_valid_o); end
            tests++; if (cmd_data_o !== 13'h0AA) begin fails++; $display("FAIL bp_data%0d got=%0h exp=aa", k, cmd_data_o); end
            tests++; if (rom_rden_o !== 1'b0) begin fails++; $display("FAIL bp_rden%0d got=%b exp=0", k, rom_rden_o); end
            tests++; if (word_cnt_o !== 5'd0) begin fails++; $display("FAIL bp_cnt%0d got=%0d exp=0", k, word_cnt_o); end
            tick();
        end
        cmd_ready_i = 1'b1;
        tests++; if (cmd_valid_o !== 1'b1) begin fails++; $display("FAIL bp_valid_release got=%b exp=1", cmd_valid_o); end
        tick();
        tests++; if (word_cnt_o !== 5'd1) begin fails++; $display("FAIL bp_cnt_after got=%0d exp=1", word_cnt_o); end
        tests++; if (cmd_valid_o !== 1'b0) begin fails++; $display("FAIL bp_valid_after got=%b exp=0", cmd_valid_o); end
        tests++; if (rom_rden_o !== 1'b1 || rom_addr_o !== 32'd4) begin fails++; $display("FAIL bp_next_rd got=%b/%0d exp=1/4", rom_rden_o, rom_addr_o); end
        n = 0;
        saw_done = 0;
        while (busy_o && n < 20) begin
            if (done_o) saw_done = 1;
            tick();
            n++;
        end
        tests++; if (saw_done !== 1'b1) begin fails++; $display("FAIL bp_done got=%b exp=1", saw_done); end
        tests++; if (word_cnt_o !== 5'd1) begin fails++; $display("FAIL bp_cnt_final got=%0d exp=1", word_cnt_o); end
    endtask

    task automatic test_last_addr();
        cmd_ready_i = 1'b1;
        exp_q = '{13'h0E0, 13'h0F0};
        run_seq(4'd14, 1'b0, 60);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL last_timeout got=%b exp=0", timed_out); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL last_ncmd got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL last_cmd%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL last_done got=%0d exp=1", done_cnt); end
        tests++; if (word_cnt_o !== 5'd2) begin fails++; $display("FAIL last_cnt got=%0d exp=2", word_cnt_o); end
    endtask

    task automatic test_abort_out();
        int n;
        cmd_ready_i = 1'b1;
        start_addr_i = 4'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!cmd_valid_o && n < 10) begin tick(); n++; end
        tick();
        n = 0;
        while (!cmd_valid_o && n < 10) begin tick(); n++; end
        tests++; if (cmd_data_o !== 13'h002) begin fails++; $display("FAIL abort_pre_data got=%0h exp=2", cmd_data_o); end
        cmd_ready_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tests++; if (cmd_valid_o !== 1'b0) begin fails++; $display("FAIL abort_valid got=%b exp=0", cmd_valid_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL abort_done got=%b exp=0", done_o); end
        tests++; if (word_cnt_o !== 5'd1) begin fails++; $display("FAIL abort_cnt got=%0d exp=1", word_cnt_o); end
        tick();
        start_addr_i = 4'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tests++; if (busy_o !== 1'b1 || rom_rden_o !== 1'b1) begin fails++; $display("FAIL restart_rd got=%b/%b exp=1/1", busy_o, rom_rden_o); end
        tests++; if (word_cnt_o !== 5'd0) begin fails++; $display("FAIL restart_cnt got=%0d exp=0", word_cnt_o); end
        cmd_ready_i = 1'b1;
        n = 0;
        while (busy_o && n < 30) begin tick(); n++; end
        tests++; if (word_cnt_o !== 5'd2) begin fails++; $display("FAIL restart_final_cnt got=%0d exp=2", word_cnt_o); end
    endtask

    task automatic test_abort_handshake();
        int n;
        cmd_ready_i = 1'b1;
        start_addr_i = 4'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!cmd_valid_o && n < 10) begin tick(); n++; end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tests++; if (word_cnt_o !== 5'd1) begin fails++; $display("FAIL abhs_cnt got=%0d exp=1", word_cnt_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abhs_busy got=%b exp=0", busy_o); end
        tests++; if (rom_rden_o !== 1'b0) begin fails++; $display("FAIL abhs_rden got=%b exp=0", rom_rden_o); end
        // abort together with start in IDLE: stays idle, count untouched
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abst_busy got=%b exp=0", busy_o); end
        tests++; if (rom_rden_o !== 1'b0) begin fails++; $display("FAIL abst_rden got=%b exp=0", rom_rden_o); end
        tests++; if (word_cnt_o !== 5'd1) begin fails++; $display("FAIL abst_cnt got=%0d exp=1", word_cnt_o); end
    endtask

    task automatic test_busy_ignored();
        cmd_ready_i = 1'b1;
        exp_q = '{13'h001, 13'h002};
        run_seq(4'd0, 1'b1, 60);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL ign_ncmd got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ign_cmd%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
        tests++; if (word_cnt_o !== 5'd2) begin fails++; $display("FAIL ign_cnt got=%0d exp=2", word_cnt_o); end
    endtask

    task automatic test_reset_mid();
        cmd_ready_i = 1'b1;
        start_addr_i = 4'd5;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tests++; if (busy_o !== 1'b1 || rom_addr_o !== 32'd5) begin fails++; $display("FAIL rstm_pre got=%b/%0d exp=1/5", busy_o, rom_addr_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests++; if (rom_addr_o !== 32'd0) begin fails++; $display("FAIL rstm_addr got=%0d exp=0", rom_addr_o); end
        tests++; if (cmd_data_o !== 13'h0) begin fails++; $display("FAIL rstm_data got=%0h exp=0", cmd_data_o); end
        tests++; if (cmd_valid_o !== 1'b0 || rom_rden_o !== 1'b0) begin fails++; $display("FAIL rstm_vr got=%b/%b exp=0/0", cmd_valid_o, rom_rden_o); end
        tests++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL rstm_bd got=%b/%b exp=0/0", busy_o, done_o); end
        tests++; if (word_cnt_o !== 5'd0) begin fails++; $display("FAIL rstm_cnt got=%0d exp=0", word_cnt_o); end
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        start_addr_i = '0;
        abort_i = 1'b0;
        cmd_ready_i = 1'b0;
        rom_data_i = '0;
        init_rom();
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_last_addr();
        test_abort_out();
        test_abort_handshake();
        test_busy_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
